ssd1306_spi_ctrl: RTL and testbench

//  Parametrised SSD1306 OLED controller over 4-wire SPI. Runs the reset/power sequence and a

---
 rtl/ssd1306_spi_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ssd1306_spi_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_ctrl.sv
// SSD1306 OLED controller over 4-wire SPI.
// Runs the panel power sequence, sends the init ROM once, then streams framebuffer
// pages to the panel. Runtime command bytes are slotted in only between frames.
module ssd1306_spi_ctrl #(
  parameter int         STARTUP_WAIT = 10000000,
  parameter int         CLK_DIV      = 1,
  parameter int         COLS         = 128,
  parameter int         PAGES        = 8,
  parameter bit         FLIP         = 1'b1,
  parameter logic [7:0] CONTRAST     = 8'h7F
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             refresh_en,
  input  logic                             cmd_valid,
  input  logic [7:0]                       cmd_data,
  output logic                             cmd_ready,
  output logic                             fb_rd,
  output logic [$clog2(COLS*PAGES)-1:0]    fb_addr,
  input  logic [7:0]                       fb_data,
  output logic                             init_done,
  output logic                             frame_done,
  output logic                             o_sclk,
  output logic                             o_sdin,
  output logic                             o_cs,
  output logic                             o_dc,
  output logic                             o_reset
);

  localparam int AW = $clog2(COLS*PAGES);
  localparam int PW = $clog2(STARTUP_WAIT + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PWR_LAST  = PW'(STARTUP_WAIT - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(COLS*PAGES - 1);
  localparam logic [4:0]    ROM_LAST  = 5'd24;
  localparam logic [2:0]    WIN_LAST  = 3'd5;

  typedef enum logic [3:0] {
    PWR_HI, PWR_LO, PWR_WAIT, INIT, IDLE, WINDOW, FB_REQ, FB_WAIT, SEND
  } state_t;

  // What the byte currently in SEND belongs to, so its completion knows where to go.
  typedef enum logic [1:0] {M_INIT, M_CMD, M_WIN, M_DATA} mode_t;

  state_t        state, next_state;
  mode_t         mode, load_mode;
  logic [PW-1:0] pwr_cnt;
  logic [DW-1:0] div_cnt;
  logic          half;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          dc_reg;
  logic [4:0]    rom_idx;
  logic [2:0]    win_idx;
  logic [AW-1:0] pix_addr;
  logic [7:0]    rom_byte, win_byte, load_byte;
  logic          load, load_dc;
  logic          pwr_last, byte_end, cmd_accept;

  assign pwr_last   = (pwr_cnt == PWR_LAST);
  assign byte_end   = (state == SEND) && half && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
  assign cmd_ready  = (state == IDLE) && init_done;
  assign cmd_accept = cmd_ready && cmd_valid;

  assign fb_rd   = (state == FB_REQ);
  assign o_sclk  = !((state == SEND) && !half);
  assign o_sdin  = (state == SEND) ? shift_reg[7] : 1'b0;
  assign o_cs    = (state == PWR_HI) || (state == PWR_LO) || (state == PWR_WAIT) || (state == IDLE);
  assign o_dc    = dc_reg;
  assign o_reset = (state != PWR_LO);

  // Init ROM contents, derived from panel geometry and orientation.
  always_comb begin
    rom_byte = 8'hE3;
    case (rom_idx)
      5'd0:  rom_byte = 8'hAE;
      5'd1:  rom_byte = 8'hD5;
      5'd2:  rom_byte = 8'h80;
      5'd3:  rom_byte = 8'hA8;
      5'd4:  rom_byte = 8'(PAGES*8 - 1);
      5'd5:  rom_byte = 8'hD3;
      5'd6:  rom_byte = 8'h00;
      5'd7:  rom_byte = 8'h40;
      5'd8:  rom_byte = 8'h8D;
      5'd9:  rom_byte = 8'h14;
      5'd10: rom_byte = 8'h20;
      5'd11: rom_byte = 8'h00;
      5'd12: rom_byte = FLIP ? 8'hA1 : 8'hA0;
      5'd13: rom_byte = FLIP ? 8'hC8 : 8'hC0;
      5'd14: rom_byte = 8'hDA;
      5'd15: rom_byte = (PAGES == 8) ? 8'h12 : 8'h02;
      5'd16: rom_byte = 8'h81;
      5'd17: rom_byte = CONTRAST;
      5'd18: rom_byte = 8'hD9;
      5'd19: rom_byte = 8'h22;
      5'd20: rom_byte = 8'hDB;
      5'd21: rom_byte = 8'h20;
      5'd22: rom_byte = 8'hA4;
      5'd23: rom_byte = 8'hA6;
      5'd24: rom_byte = 8'hAF;
      default: rom_byte = 8'hE3;
    endcase
  end

  // Column/page window covering the whole panel, sent before every frame.
  always_comb begin
    win_byte = 8'h00;
    case (win_idx)
      3'd0: win_byte = 8'h21;
      3'd1: win_byte = 8'h00;
      3'd2: win_byte = 8'(COLS - 1);
      3'd3: win_byte = 8'h22;
      3'd4: win_byte = 8'h00;
      3'd5: win_byte = 8'(PAGES - 1);
      default: win_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PWR_HI;
    else        state <= next_state;
  end

  // Next-state decode and selection of the next byte to shift out.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_byte  = 8'h00;
    load_dc    = 1'b0;
    load_mode  = mode;
    case (state)
      PWR_HI:   if (pwr_last) next_state = PWR_LO;
      PWR_LO:   if (pwr_last) next_state = PWR_WAIT;
      PWR_WAIT: if (pwr_last) next_state = INIT;
      INIT: begin
        load       = 1'b1;
        load_byte  = rom_byte;
        load_mode  = M_INIT;
        next_state = SEND;
      end
      IDLE: begin
        if (cmd_accept) begin
          load       = 1'b1;
          load_byte  = cmd_data;
          load_mode  = M_CMD;
          next_state = SEND;
        end else if (refresh_en) begin
          next_state = WINDOW;
        end
      end
      WINDOW: begin
        load       = 1'b1;
        load_byte  = win_byte;
        load_mode  = M_WIN;
        next_state = SEND;
      end
      FB_REQ: next_state = FB_WAIT;
      FB_WAIT: begin
        load       = 1'b1;
        load_byte  = fb_data;
        load_dc    = 1'b1;
        load_mode  = M_DATA;
        next_state = SEND;
      end
      SEND: begin
        if (byte_end) begin
          case (mode)
            M_INIT:  next_state = (rom_idx == ROM_LAST) ? IDLE : INIT;
            M_CMD:   next_state = IDLE;
            M_WIN:   next_state = (win_idx == WIN_LAST) ? FB_REQ : WINDOW;
            M_DATA:  next_state = (pix_addr == ADDR_LAST) ? IDLE : FB_REQ;
            default: next_state = IDLE;
          endcase
        end
      end
      default: next_state = PWR_HI;
    endcase
  end

  // Times each of the three power-sequence phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_cnt <= '0;
    end else if ((state == PWR_HI) || (state == PWR_LO) || (state == PWR_WAIT)) begin
      pwr_cnt <= pwr_last ? '0 : pwr_cnt + PW'(1);
    end else begin
      pwr_cnt <= '0;
    end
  end

  // Serialiser: low half then high half per bit, MSB first, dc latched with the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      dc_reg    <= 1'b0;
      mode      <= M_INIT;
      div_cnt   <= '0;
      half      <= 1'b0;
      bit_cnt   <= 3'd0;
    end else if (load) begin
      shift_reg <= load_byte;
      dc_reg    <= load_dc;
      mode      <= load_mode;
      div_cnt   <= '0;
      half      <= 1'b0;
      bit_cnt   <= 3'd0;
    end else if (state == SEND) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        half    <= ~half;
        if (half) begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Sequence bookkeeping advanced at the end of each byte: ROM, window and pixel indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_idx    <= 5'd0;
      win_idx    <= 3'd0;
      pix_addr   <= '0;
      fb_addr    <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (byte_end) begin
        case (mode)
          M_INIT: begin
            if (rom_idx == ROM_LAST) begin
              rom_idx   <= 5'd0;
              init_done <= 1'b1;
            end else begin
              rom_idx <= rom_idx + 5'd1;
            end
          end
          M_WIN: begin
            if (win_idx == WIN_LAST) begin
              win_idx <= 3'd0;
              fb_addr <= pix_addr;
            end else begin
              win_idx <= win_idx + 3'd1;
            end
          end
          M_DATA: begin
            if (pix_addr == ADDR_LAST) begin
              pix_addr   <= '0;
              frame_done <= 1'b1;
            end else begin
              pix_addr <= pix_addr + AW'(1);
              fb_addr  <= pix_addr + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_ctrl.sv
// Self-checking bench for ssd1306_spi_ctrl on a small 8x32 geometry.
// The panel side decodes SPI bytes and compares them with the byte stream the
// display protocol calls for; the host side serves a random framebuffer.
module tb_ssd1306_spi_ctrl;

  localparam int SW = 4;
  localparam int CD = 2;
  localparam int NC = 8;
  localparam int NP = 4;
  localparam int NB = NC*NP;
  localparam int AW = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          refresh_en;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          cmd_ready;
  logic          fb_rd;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data = 8'h00;
  logic          init_done;
  logic          frame_done;
  logic          o_sclk, o_sdin, o_cs, o_dc, o_reset;

  int vectors    = 0;
  int miscompares = 0;

  logic [8:0]    exp_q[$];
  int            addr_q[$];
  logic [7:0]    fb_mem [NB];
  logic [7:0]    rom_exp [25];

  int            cyc = 0;
  int            mon_bits = 0;
  int            last_rise = 0;
  logic [7:0]    mon_sh = 8'h00;
  logic          mon_dc = 1'b0;
  logic          prev_sclk = 1'b1;
  int            data_cnt = 0;

  ssd1306_spi_ctrl #(
    .STARTUP_WAIT(SW), .CLK_DIV(CD), .COLS(NC), .PAGES(NP), .FLIP(1'b1), .CONTRAST(8'h7F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .refresh_en(refresh_en), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .init_done(init_done), .frame_done(frame_done),
    .o_sclk(o_sclk), .o_sdin(o_sdin), .o_cs(o_cs), .o_dc(o_dc), .o_reset(o_reset)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ref_en, input logic valid, input logic [7:0] data);
    refresh_en = ref_en;
    cmd_valid  = valid;
    cmd_data   = data;
  endtask

  // Panel-side SPI decoder: a byte is eight SCLK rising edges while CS is low.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_bits  = 0;
        prev_sclk = 1'b1;
      end else begin
        if (!prev_sclk && o_sclk && !o_cs) begin
          if (mon_bits == 0) begin
            mon_dc = o_dc;
          end else begin
            checkOutput("sclk_period", cyc - last_rise, 2*CD);
            checkOutput("dc_stable", o_dc, mon_dc);
          end
          last_rise = cyc;
          mon_sh    = {mon_sh[6:0], o_sdin};
          mon_bits++;
          if (mon_bits == 8) begin
            mon_bits = 0;
            checkOutput("spi_byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) checkOutput("spi_byte", {mon_dc, mon_sh}, exp_q.pop_front());
            if (mon_dc) data_cnt++;
          end
        end
        prev_sclk = o_sclk;
      end
    end
  end

  // Host-side framebuffer: data is presented in the cycle after the read strobe only.
  initial begin
    logic          rd_pend;
    logic [AW-1:0] addr_pend;
    rd_pend   = 1'b0;
    addr_pend = '0;
    forever begin
      @(negedge clk);
      if (rd_pend) fb_data = fb_mem[addr_pend];
      else         fb_data = 8'($urandom);
      rd_pend   = fb_rd && rst_n;
      addr_pend = fb_addr;
      if (rd_pend) addr_q.push_back(int'(fb_addr));
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushFrame();
    logic [7:0] win [6];
    win = '{8'h21, 8'h00, 8'(NC-1), 8'h22, 8'h00, 8'(NP-1)};
    foreach (win[i]) exp_q.push_back({1'b0, win[i]});
    for (int a = 0; a < NB; a++) exp_q.push_back({1'b1, fb_mem[a]});
    data_cnt = 0;
    addr_q.delete();
  endtask

  task automatic fillRandom();
    for (int a = 0; a < NB; a++) fb_mem[a] = 8'($urandom);
  endtask

  task automatic powerUpCheck();
    foreach (rom_exp[i]) exp_q.push_back({1'b0, rom_exp[i]});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3*SW; i++) begin
      checkOutput("o_reset_seq", o_reset, (i < SW || i >= 2*SW) ? 1 : 0);
      checkOutput("cs_power", o_cs, 1);
      @(negedge clk);
    end
    checkOutput("cs_low_init", o_cs, 0);
  endtask

  task automatic waitDrain(input int budget, input string tag);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput(tag, exp_q.size(), 0);
  endtask

  task automatic waitInitDone();
    for (int i = 0; i < 20 && !init_done; i++) @(negedge clk);
    checkOutput("init_done_rise", init_done, 1);
    checkOutput("idle_cs_high", o_cs, 1);
    checkOutput("idle_sclk_high", o_sclk, 1);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic waitData(input int n, input int budget);
    for (int i = 0; i < budget && data_cnt < n; i++) @(negedge clk);
    checkOutput("data_progress", data_cnt >= n, 1);
  endtask

  task automatic waitFrameDone(input int budget, input bit check_ready);
    int cs_high = 0;
    bit seen_rd = 1'b0;
    bit got     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      if (fb_rd) seen_rd = 1'b1;
      if (seen_rd && o_cs) cs_high++;
      if (check_ready) checkOutput("cmd_ready_mid_frame", cmd_ready, 0);
    end
    checkOutput("frame_done_seen", got, 1);
    checkOutput("cs_low_in_frame", cs_high, 0);
    checkOutput("frame_bytes_drained", exp_q.size(), 0);
    checkOutput("fb_addr_count", addr_q.size(), NB);
    for (int i = 0; i < addr_q.size() && i < NB; i++) checkOutput("fb_addr", addr_q[i], i);
  endtask

  task automatic sendCommand(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    applyStimulus(refresh_en, 1'b1, b);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    checkOutput("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    applyStimulus(refresh_en, 1'b0, 8'h00);
    checkOutput("cmd_ready_busy", cmd_ready, 0);
    waitDrain(200, "cmd_sent");
  endtask

  initial begin
    int idle_rd, idle_cs_low, idle_fd;
    bit found;

    rom_exp = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'(NP*8-1), 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, (NP == 8) ? 8'h12 : 8'h02, 8'h81, 8'h7F,
                8'hD9, 8'h22, 8'hDB, 8'h20, 8'hA4, 8'hA6, 8'hAF};
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    checkOutput("rst_sclk", o_sclk, 1);
    checkOutput("rst_sdin", o_sdin, 0);
    checkOutput("rst_cs", o_cs, 1);
    checkOutput("rst_dc", o_dc, 0);
    checkOutput("rst_reset", o_reset, 1);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_fb_rd", fb_rd, 0);
    checkOutput("rst_fb_addr", fb_addr, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_frame_done", frame_done, 0);

    $display("[TB] power-up and init ROM");
    powerUpCheck();
    waitDrain(2000, "init_rom_drained");
    checkOutput("init_done_before_end", init_done, 0);
    waitInitDone();

    $display("[TB] frame with addr^5A pattern");
    for (int a = 0; a < NB; a++) fb_mem[a] = 8'(a) ^ 8'h5A;
    pushFrame();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitFrameDone(3000, 1'b0);

    $display("[TB] command held off until frame end");
    fillRandom();
    pushFrame();
    waitData(10, 2000);
    applyStimulus(1'b1, 1'b1, 8'hA7);
    waitFrameDone(3000, 1'b1);
    checkOutput("cmd_ready_after_frame", cmd_ready, 1);
    exp_q.push_back({1'b0, 8'hA7});
    fillRandom();
    pushFrame();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("frame_done_pulse", frame_done, 0);
    checkOutput("cmd_ready_sending", cmd_ready, 0);

    $display("[TB] refresh dropped mid-frame");
    waitData(15, 2000);
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitFrameDone(3000, 1'b0);
    idle_rd = 0; idle_cs_low = 0; idle_fd = 0;
    repeat (60) begin
      @(negedge clk);
      if (fb_rd) idle_rd++;
      if (!o_cs) idle_cs_low++;
      if (frame_done) idle_fd++;
    end
    checkOutput("idle_no_fb_rd", idle_rd, 0);
    checkOutput("idle_cs_high_all", idle_cs_low, 0);
    checkOutput("idle_no_frame_done", idle_fd, 0);

    $display("[TB] random runtime commands");
    repeat (4) sendCommand(8'($urandom));
    repeat (4) @(negedge clk);
    checkOutput("cs_high_after_cmds", o_cs, 1);

    $display("[TB] reset in the middle of a data byte");
    fillRandom();
    pushFrame();
    applyStimulus(1'b1, 1'b0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_cnt >= 2 && mon_bits == 3 && mon_dc) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("mid_byte_found", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_cs", o_cs, 1);
    checkOutput("abort_sclk", o_sclk, 1);
    checkOutput("abort_dc", o_dc, 0);
    checkOutput("abort_sdin", o_sdin, 0);
    checkOutput("abort_init_done", init_done, 0);
    checkOutput("abort_fb_rd", fb_rd, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    addr_q.delete();
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    powerUpCheck();
    waitDrain(2000, "init_rom_redrained");
    waitInitDone();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
